// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline.
// Handles load-use bubbles, EX redirects, data-memory wait freezes with a timeout
// fault, and stall/flush performance counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       ex_rd_addr,
  input  logic             ex_write_reg_enable,
  input  logic [2:0]       ex_read_ram_flag,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_hold,
  output logic             if_id_hold,
  output logic             if_id_flush,
  output logic             id_ex_hold,
  output logic             id_ex_flush,
  output logic             ex_mem_hold,
  output logic             mem_wb_flush,
  output logic             mem_fault,
  output logic [1:0]       ctrl_state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {RUN = 2'd0, WAIT = 2'd1, FAULT = 2'd2} state_e;

  // wait_cnt reaching this value while still waiting means the next edge is the
  // MEM_TIMEOUT-th consecutive wait edge (the first one is spent in RUN).
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic             fault_q, fault_d;
  logic [CNT_W-1:0] stall_q, flush_q;

  logic mem_wait, freeze, rs1_hit, rs2_hit, load_use, redirect_act;

  assign mem_wait     = mem_req & ~mem_ready;
  assign freeze       = mem_wait | (state_q == FAULT);
  assign rs1_hit      = id_rs1_used & (id_rs1_addr == ex_rd_addr);
  assign rs2_hit      = id_rs2_used & (id_rs2_addr == ex_rd_addr);
  assign load_use     = (ex_read_ram_flag != 3'd0) & ex_write_reg_enable &
                        (ex_rd_addr != 5'd0) & (rs1_hit | rs2_hit);
  assign redirect_act = ~freeze & ex_redirect;

  // Pipeline controls: freeze beats redirect, redirect beats load-use.
  always_comb begin
    pc_hold      = 1'b0;
    if_id_hold   = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_hold   = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_hold  = 1'b0;
    mem_wb_flush = 1'b0;
    if (freeze) begin
      pc_hold      = 1'b1;
      if_id_hold   = 1'b1;
      id_ex_hold   = 1'b1;
      ex_mem_hold  = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (ex_redirect) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
    end else if (load_use) begin
      pc_hold      = 1'b1;
      if_id_hold   = 1'b1;
      id_ex_flush  = 1'b1;
    end
  end

  // Memory-wait FSM next state; FAULT is only left through reset.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    fault_d = fault_q;
    unique case (state_q)
      RUN: begin
        if (mem_wait) begin
          state_d = WAIT;
          wait_d  = 8'd1;
        end
      end
      WAIT: begin
        if (!mem_wait) begin
          state_d = RUN;
          wait_d  = 8'd0;
        end else if (wait_q == WAIT_LAST) begin
          state_d = FAULT;
          fault_d = 1'b1;
        end else begin
          wait_d  = wait_q + 8'd1;
        end
      end
      default: begin
        state_d = FAULT;
      end
    endcase
  end

  // FSM state, wait counter and sticky fault.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      wait_q  <= 8'd0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      fault_q <= fault_d;
    end
  end

  // Performance counters, wrapping naturally at 2^CNT_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (pc_hold)      stall_q <= stall_q + CNT_W'(1);
      if (redirect_act) flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign mem_fault  = fault_q;
  assign ctrl_state = state_q;
  assign stall_cnt  = stall_q;
  assign flush_cnt  = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances (timeout 16 / 32-bit counters and
// timeout 4 / 4-bit counters) share stimulus and are checked against a
// rule-level model every negedge, plus hand-computed literal checks.
module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] a1, a2, rd;
  logic u1, u2, wre, redir, mreq, mrdy;
  logic [2:0] lflag;

  logic [6:0]  v16, v4;
  logic        f16, f4;
  logic [1:0]  s16, s4;
  logic [31:0] sc16, fc16;
  logic [3:0]  sc4, fc4;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(32)) d16 (
    .clk(clk), .rst(rst), .id_rs1_addr(a1), .id_rs2_addr(a2),
    .id_rs1_used(u1), .id_rs2_used(u2), .ex_rd_addr(rd),
    .ex_write_reg_enable(wre), .ex_read_ram_flag(lflag), .ex_redirect(redir),
    .mem_req(mreq), .mem_ready(mrdy),
    .pc_hold(v16[6]), .if_id_hold(v16[5]), .if_id_flush(v16[4]),
    .id_ex_hold(v16[3]), .id_ex_flush(v16[2]), .ex_mem_hold(v16[1]),
    .mem_wb_flush(v16[0]), .mem_fault(f16), .ctrl_state(s16),
    .stall_cnt(sc16), .flush_cnt(fc16));

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) d4 (
    .clk(clk), .rst(rst), .id_rs1_addr(a1), .id_rs2_addr(a2),
    .id_rs1_used(u1), .id_rs2_used(u2), .ex_rd_addr(rd),
    .ex_write_reg_enable(wre), .ex_read_ram_flag(lflag), .ex_redirect(redir),
    .mem_req(mreq), .mem_ready(mrdy),
    .pc_hold(v4[6]), .if_id_hold(v4[5]), .if_id_flush(v4[4]),
    .id_ex_hold(v4[3]), .id_ex_flush(v4[2]), .ex_mem_hold(v4[1]),
    .mem_wb_flush(v4[0]), .mem_fault(f4), .ctrl_state(s4),
    .stall_cnt(sc4), .flush_cnt(fc4));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  // Per instance: length of the current run of consecutive waiting edges, a
  // faulted flag, and plain integer counters.
  int run_len [2] = '{0, 0};
  bit flt     [2] = '{0, 0};
  int scnt    [2] = '{0, 0};
  int fcnt    [2] = '{0, 0};
  int tmo     [2] = '{16, 4};

  function automatic bit m_frozen(int i);
    return flt[i] || (mreq && !mrdy);
  endfunction

  function automatic bit m_lu();
    return (lflag != 0) && wre && (rd != 0) &&
           ((u1 && a1 == rd) || (u2 && a2 == rd));
  endfunction

  // {pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush, ex_mem_hold, mem_wb_flush}
  function automatic logic [6:0] m_vec(int i);
    if (m_frozen(i)) return 7'b1101011;
    if (redir)       return 7'b0010100;
    if (m_lu())      return 7'b1100100;
    return 7'b0000000;
  endfunction

  function automatic logic [1:0] m_state(int i);
    if (flt[i]) return 2'd2;
    return (run_len[i] > 0) ? 2'd1 : 2'd0;
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        run_len[i] = 0; flt[i] = 0; scnt[i] = 0; fcnt[i] = 0;
      end else begin
        logic [6:0] v;
        bit fr;
        v  = m_vec(i);
        fr = m_frozen(i);
        if (v[6]) scnt[i] = scnt[i] + 1;
        if (!fr && redir) fcnt[i] = fcnt[i] + 1;
        if (!flt[i]) begin
          if (mreq && !mrdy) begin
            run_len[i] = run_len[i] + 1;
            if (run_len[i] >= tmo[i]) flt[i] = 1;
          end else begin
            run_len[i] = 0;
          end
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    chk("d16 ctrl_vec", 32'(v16), 32'(m_vec(0)));
    chk("d16 state",    32'(s16), 32'(m_state(0)));
    chk("d16 fault",    32'(f16), 32'(flt[0]));
    chk("d16 stall",    sc16, scnt[0]);
    chk("d16 flush",    fc16, fcnt[0]);
    chk("d4 ctrl_vec",  32'(v4), 32'(m_vec(1)));
    chk("d4 state",     32'(s4), 32'(m_state(1)));
    chk("d4 fault",     32'(f4), 32'(flt[1]));
    chk("d4 stall",     32'(sc4), scnt[1] & 15);
    chk("d4 flush",     32'(fc4), fcnt[1] & 15);
  end

  // ---------------- stimulus ----------------
  task automatic quiet();
    a1 = 5'd0; a2 = 5'd0; rd = 5'd0; u1 = 0; u2 = 0; wre = 0;
    lflag = 3'd0; redir = 0; mreq = 0; mrdy = 0;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // Called at posedge+1; async pulse lands mid-cycle, before the negedge.
  task automatic pulse_rst();
    quiet();
    #1 rst = 1'b1;
    #1;
    chk("rst d16 vec",   32'(v16), 32'd0);
    chk("rst d16 state", 32'(s16), 32'd0);
    chk("rst d16 cnts",  sc16 | fc16, 32'd0);
    chk("rst d4 fault",  32'(f4), 32'd0);
    chk("rst d4 state",  32'(s4), 32'd0);
    chk("rst d4 cnts",   32'(sc4 | fc4), 32'd0);
    #1 rst = 1'b0;
    cyc();
  endtask

  task automatic set_load(input logic [4:0] r);
    lflag = 3'b010; wre = 1; rd = r;
  endtask

  initial begin
    quiet();
    #2;
    chk("reset vec",   32'(v16), 32'd0);
    chk("reset fault", 32'(f16), 32'd0);
    chk("reset stall", sc16, 32'd0);
    cyc();
    rst = 1'b0;
    cyc();

    // Load-use through rs2: one bubble.
    set_load(5'd5); a2 = 5'd5; u2 = 1; a1 = 5'd3; u1 = 1;
    #1;
    chk("lu pc_hold",  32'(v16[6]), 32'd1);
    chk("lu idex_fl",  32'(v16[2]), 32'd1);
    cyc();
    lflag = 3'd0; wre = 0; rd = 5'd0;     // bubble now in EX
    #1;
    chk("lu clr vec",  32'(v16), 32'd0);
    chk("lu stall=1",  sc16, 32'd1);
    cyc();

    // No-stall cases.
    pulse_rst();
    set_load(5'd0); a1 = 5'd0; u1 = 1; a2 = 5'd0; u2 = 1;
    cyc();
    set_load(5'd5); a1 = 5'd5; a2 = 5'd5; u1 = 0; u2 = 0;
    #1 chk("nolu vec", 32'(v16), 32'd0);
    cyc();
    quiet();
    #1 chk("nolu stall", sc16, 32'd0);
    cyc();

    // Redirect beats load-use.
    pulse_rst();
    set_load(5'd7); a1 = 5'd7; u1 = 1; redir = 1;
    #1;
    chk("rdlu iffl", 32'(v16[4]), 32'd1);
    chk("rdlu pc",   32'(v16[6]), 32'd0);
    cyc();
    quiet();
    #1;
    chk("rdlu flush", fc16, 32'd1);
    chk("rdlu stall", sc16, 32'd0);
    cyc();

    // Three-cycle memory wait, then completion.
    pulse_rst();
    mreq = 1; mrdy = 0;
    cyc(); cyc();
    #1 chk("mw state", 32'(s16), 32'd1);
    cyc();
    mrdy = 1;
    #1 chk("mw done vec", 32'(v16), 32'd0);
    cyc();
    quiet();
    #1;
    chk("mw stall", sc16, 32'd3);
    chk("mw state0", 32'(s16), 32'd0);
    chk("mw nofault", 32'(f4), 32'd0);
    cyc();

    // Redirect pending across a 2-cycle wait.
    pulse_rst();
    redir = 1; mreq = 1; mrdy = 0;
    #1 chk("pr frozen iffl", 32'(v16[4]), 32'd0);
    cyc(); cyc();
    mrdy = 1;
    #1 chk("pr iffl", 32'(v16[4]), 32'd1);
    cyc();
    quiet();
    #1;
    chk("pr flush", fc16, 32'd1);
    chk("pr stall", sc16, 32'd2);
    cyc();

    // Timeout on the 4-cycle instance, then wrap of its 4-bit stall counter.
    pulse_rst();
    mreq = 1; mrdy = 0;
    repeat (3) cyc();
    #1 chk("to pre-fault", 32'(f4), 32'd0);
    cyc();
    #1;
    chk("to fault", 32'(f4), 32'd1);
    chk("to state", 32'(s4), 32'd2);
    chk("to d16 wait", 32'(s16), 32'd1);
    mrdy = 1;
    #1 chk("to still frozen", 32'(v4[6]), 32'd1);
    repeat (15) cyc();
    chk("to stall wrap", 32'(sc4), 32'd3);
    chk("to d16 stall", sc16, 32'd4);
    pulse_rst();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline. Drives the hold and flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use hazards between ID and EX, and control redirects (taken branch/jump) resolved in EX.
- Freezes the pipeline on multi-cycle data-memory waits. Raises a sticky fault if a wait exceeds a timeout.
- Keeps stall/flush performance counters.

Parameters:
- MEM_TIMEOUT, 16, consecutive wait cycles after which the fault is declared (legal range 2..255).
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_rs1_addr  in  5  rs1 index of the instruction in ID.
- id_rs2_addr  in  5  rs2 index of the instruction in ID.
- id_rs1_used  in  1  ID instruction reads rs1.
- id_rs2_used  in  1  ID instruction reads rs2.
- ex_rd_addr  in  5  rd index of the instruction in EX.
- ex_write_reg_enable  in  1  EX instruction writes rd.
- ex_read_ram_flag  in  3  EX load type; nonzero means the instruction is a load.
- ex_redirect  in  1  EX resolved a taken branch or jump this cycle.
- mem_req  in  1  MEM stage has an outstanding data-memory access.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_hold  out  1  PC keeps its value.
- if_id_hold  out  1  IF/ID keeps its contents.
- if_id_flush  out  1  IF/ID loads a bubble.
- id_ex_hold  out  1  ID/EX keeps its contents.
- id_ex_flush  out  1  ID/EX loads a bubble (drives the register's flush input).
- ex_mem_hold  out  1  EX/MEM keeps its contents.
- mem_wb_flush  out  1  MEM/WB loads a bubble.
- mem_fault  out  1  sticky timeout fault.
- ctrl_state  out  2  FSM state: 0=RUN, 1=WAIT, 2=FAULT.
- stall_cnt  out  CNT_W  count of cycles with pc_hold=1.
- flush_cnt  out  CNT_W  count of redirect flushes.

Behaviour:
- Combinational conditions:
  - freeze = (mem_req & ~mem_ready) | (state==FAULT).
  - load_use = (ex_read_ram_flag!=0) & ex_write_reg_enable & (ex_rd_addr!=0) & ((id_rs1_used & id_rs1_addr==ex_rd_addr) | (id_rs2_used & id_rs2_addr==ex_rd_addr)).
- Output priority, all outputs combinational from the current state and inputs:
  - freeze: pc_hold, if_id_hold, id_ex_hold, ex_mem_hold and mem_wb_flush are 1; both flushes on IF/ID and ID/EX are 0. redirect and load_use are ignored this cycle; they are re-evaluated after the freeze because EX and ID are held.
  - else ex_redirect: if_id_flush=1 and id_ex_flush=1; all holds 0; PC takes the branch target.
  - else load_use: pc_hold=1, if_id_hold=1, id_ex_flush=1; everything else 0.
  - else: all outputs 0.
- Load-use inserts exactly one bubble. The next cycle EX holds the bubble (ex_read_ram_flag=0), so the hazard clears without extra state.
- A load targeting x0 never stalls.
- FSM:
  - RUN: if mem_req & ~mem_ready, go to WAIT and set wait_cnt=1.
  - WAIT:
    - If mem_ready or ~mem_req, go to RUN and clear wait_cnt.
    - Else if wait_cnt==MEM_TIMEOUT-1, go to FAULT and set mem_fault=1.
    - Else increment wait_cnt.
  - FAULT: terminal until rst; freeze stays asserted.
- Timing: MEM_TIMEOUT consecutive wait cycles (counting the first cycle in RUN) cause FAULT at the MEM_TIMEOUT-th rising edge.
- A completing access (mem_req & mem_ready) never freezes, including in its first cycle.
- Counters:
  - stall_cnt increments on every edge where pc_hold=1, freeze cycles included.
  - flush_cnt increments on every edge where the redirect action is taken.
  - Both counters wrap modulo 2^CNT_W.
- Reset, asynchronous, immediate: state=RUN, wait_cnt=0, mem_fault=0, stall_cnt=0, flush_cnt=0. With quiescent inputs all combinational outputs read 0.
- Reset asserted mid-WAIT or mid-FAULT aborts to RUN immediately. The outstanding memory access is the memory's responsibility.

Test Plan:
- Load-use: EX holds a load with rd=5, ID has rs2=5 used, 1 cycle → pc_hold=if_id_hold=id_ex_flush=1 for exactly 1 cycle; stall_cnt=1; next cycle all outputs 0.
- No stall cases: a load with rd=0, or rd=5 with id_rs1_used=id_rs2_used=0 → no stall; stall_cnt stays 0.
- Redirect coinciding with load-use: ex_redirect=1 and load_use=1 in the same cycle → if_id_flush=id_ex_flush=1, pc_hold=0; flush_cnt=1, stall_cnt=0.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles then 1, MEM_TIMEOUT=16 → full freeze for 3 cycles; ctrl_state goes 1 then back to 0; stall_cnt=3; no fault.
- Timeout: MEM_TIMEOUT=4, mem_ready held 0 → mem_fault=1 and ctrl_state=2 after the 4th edge; freeze persists after mem_ready=1; an async rst pulse mid-cycle clears everything immediately.
- Freeze with pending redirect: ex_redirect=1 during a 2-cycle wait → no flush while frozen; flush on the first unfrozen cycle; flush_cnt=1.
